// File: rtl/imggen_pkg.sv
// Shared constants, types and byte-sequence helpers for the image generator.
package imggen_pkg;

  // Grid and screen geometry defaults
  localparam int unsigned DefGridW  = 16;
  localparam int unsigned DefGridH  = 12;
  localparam int unsigned DefCellPx = 20;

  // LCD command set
  localparam logic [7:0] CmdSwReset  = 8'h01;
  localparam logic [7:0] CmdSleepOut = 8'h11;
  localparam logic [7:0] CmdPixFmt   = 8'h3A;
  localparam logic [7:0] CmdDispOn   = 8'h29;
  localparam logic [7:0] CmdColSet   = 8'h2A;
  localparam logic [7:0] CmdPageSet  = 8'h2B;
  localparam logic [7:0] CmdMemWr    = 8'h2C;
  localparam logic [7:0] PixFmt16    = 8'h55;

  // Byte counts of the fixed command sequences
  localparam int unsigned InitLen   = 5;
  localparam int unsigned WinHdrLen = 11;

  // RGB565 palette indexed by the colour-cycle position
  localparam logic [15:0] Palette [8] = '{
    16'hFFFF, 16'hF800, 16'h07E0, 16'h001F, 16'hFFE0, 16'hF81F, 16'h07FF, 16'h8410
  };

  typedef enum logic [2:0] {StPowerup, StInit, StClear, StIdle, StDraw} imggen_state_e;
  typedef enum logic [1:0] {DirUp, DirDown, DirLeft, DirRight} imggen_dir_e;

  // Init sequence as {dcx, byte}
  function automatic logic [8:0] init_byte(input logic [3:0] idx);
    logic [8:0] b;
    case (idx)
      4'd0:    b = {1'b0, CmdSwReset};
      4'd1:    b = {1'b0, CmdSleepOut};
      4'd2:    b = {1'b0, CmdPixFmt};
      4'd3:    b = {1'b1, PixFmt16};
      default: b = {1'b0, CmdDispOn};
    endcase
    return b;
  endfunction

  // Window set-up header (column set, page set, memory write) as {dcx, byte}
  function automatic logic [8:0] win_byte(input logic [3:0] idx, input logic [15:0] x0,
                                          input logic [15:0] x1, input logic [15:0] y0,
                                          input logic [15:0] y1);
    logic [8:0] b;
    case (idx)
      4'd0:    b = {1'b0, CmdColSet};
      4'd1:    b = {1'b1, x0[15:8]};
      4'd2:    b = {1'b1, x0[7:0]};
      4'd3:    b = {1'b1, x1[15:8]};
      4'd4:    b = {1'b1, x1[7:0]};
      4'd5:    b = {1'b0, CmdPageSet};
      4'd6:    b = {1'b1, y0[15:8]};
      4'd7:    b = {1'b1, y0[7:0]};
      4'd8:    b = {1'b1, y1[15:8]};
      4'd9:    b = {1'b1, y1[7:0]};
      default: b = {1'b0, CmdMemWr};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// 8080-style byte writer: one byte per two clocks, wr low in the first, high in the second.
module lcd_bus_writer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       valid_i,
  input  logic [8:0] data_i,   // {dcx, byte}
  output logic       ready_o,
  output logic       dcx_o,
  output logic       wr_o,
  output logic [7:0] d_o
);

  logic       low_q;
  logic       dcx_q;
  logic       wr_q;
  logic [7:0] d_q;

  assign ready_o = ~low_q;
  assign dcx_o   = dcx_q;
  assign wr_o    = wr_q;
  assign d_o     = d_q;

  // Launch a byte with wr low, then raise wr while holding dcx/D
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      low_q <= 1'b0;
      dcx_q <= 1'b1;
      wr_q  <= 1'b1;
      d_q   <= 8'h00;
    end else if (low_q) begin
      low_q <= 1'b0;
      wr_q  <= 1'b1;
    end else if (valid_i) begin
      low_q <= 1'b1;
      wr_q  <= 1'b0;
      dcx_q <= data_i[8];
      d_q   <= data_i[7:0];
    end
  end

endmodule

// File: rtl/complete_top.sv
// Image-generator top: button-driven cursor painting grid cells on a parallel LCD.
// Optional tone generator on sound_out is built when IMGGEN_SOUND_EN is defined.
module complete_top
  import imggen_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES = 100000,
  parameter int unsigned GRID_W         = DefGridW,
  parameter int unsigned GRID_H         = DefGridH,
  parameter int unsigned CELL_PX        = DefCellPx,
  parameter int unsigned TONE_CYCLES    = 20000,
  parameter int unsigned TONE_HALF      = 50
) (
  input  logic       hwclk,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  input  logic       mode_pb,
  input  logic       KeyEnc,
  output logic       dcx,
  output logic       wr,
  output logic [7:0] D,
  output logic [5:0] sound_out
);

  localparam int unsigned ScreenW = GRID_W * CELL_PX;
  localparam int unsigned ScreenH = GRID_H * CELL_PX;

  localparam logic [19:0] PwrLast   = 20'(POWERUP_CYCLES - 1);
  localparam logic [19:0] ClearLast = 20'(2 * ScreenW * ScreenH - 1);
  localparam logic [19:0] DrawLast  = 20'(2 * CELL_PX * CELL_PX - 1);
  localparam logic [7:0]  XMax      = 8'(GRID_W - 1);
  localparam logic [7:0]  YMax      = 8'(GRID_H - 1);
  localparam logic [7:0]  XRst      = 8'(GRID_W / 2);
  localparam logic [7:0]  YRst      = 8'(GRID_H / 2);
  localparam logic [15:0] ScrX1     = 16'(ScreenW - 1);
  localparam logic [15:0] ScrY1     = 16'(ScreenH - 1);
  localparam logic [15:0] CellPx    = 16'(CELL_PX);
  localparam logic [15:0] CellEnd   = 16'(CELL_PX - 1);

  // Button order: up, down, left, right, mode_pb, KeyEnc
  logic [5:0] btn_raw, sync1_q, sync2_q, prev_q, btn_edge;

  imggen_state_e state_q, state_d;
  logic [3:0]    step_q, step_d;
  logic [19:0]   pix_q, pix_d;
  logic [19:0]   pwr_q, pwr_d;
  logic [7:0]    cx_q, cx_d, cy_q, cy_d;
  logic [15:0]   draw_col_q, draw_col_d;
  logic          pend_valid_q, pend_valid_d;
  imggen_dir_e   pend_dir_q, pend_dir_d, edge_dir;
  logic          pen_down_q;
  logic [2:0]    col_idx_q;

  logic [15:0] win_x0, win_x1, win_y0, win_y1, pix_colour;
  logic [19:0] pix_last;
  logic        bus_valid, bus_ready;
  logic [8:0]  bus_byte;
  logic        tone_start, tone_bump;

  assign btn_raw  = {KeyEnc, mode_pb, right, left, down, up};
  assign btn_edge = sync2_q & ~prev_q;

  // Two-stage synchroniser plus previous-value register for edge detection
  always_ff @(posedge hwclk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Direction priority among simultaneous edges: up > down > left > right
  always_comb begin
    edge_dir = DirRight;
    if (btn_edge[0])      edge_dir = DirUp;
    else if (btn_edge[1]) edge_dir = DirDown;
    else if (btn_edge[2]) edge_dir = DirLeft;
  end

  // Pen and colour react to their edges in every state
  always_ff @(posedge hwclk or negedge reset) begin
    if (!reset) begin
      pen_down_q <= 1'b1;
      col_idx_q  <= 3'd0;
    end else begin
      if (btn_edge[4]) pen_down_q <= ~pen_down_q;
      if (btn_edge[5]) col_idx_q  <= col_idx_q + 3'd1;
    end
  end

  // Window and pixel source: whole screen in black for CLEAR, cursor cell otherwise
  always_comb begin
    if (state_q == StDraw) begin
      win_x0     = 16'(cx_q) * CellPx;
      win_x1     = win_x0 + CellEnd;
      win_y0     = 16'(cy_q) * CellPx;
      win_y1     = win_y0 + CellEnd;
      pix_colour = draw_col_q;
      pix_last   = DrawLast;
    end else begin
      win_x0     = 16'h0000;
      win_x1     = ScrX1;
      win_y0     = 16'h0000;
      win_y1     = ScrY1;
      pix_colour = 16'h0000;
      pix_last   = ClearLast;
    end
  end

  // Sequencer next-state, bus requests and request service
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    pix_d        = pix_q;
    pwr_d        = pwr_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    draw_col_d   = draw_col_q;
    pend_valid_d = pend_valid_q;
    pend_dir_d   = pend_dir_q;
    bus_valid    = 1'b0;
    bus_byte     = 9'h000;
    tone_start   = 1'b0;
    tone_bump    = 1'b0;

    case (state_q)
      StPowerup: begin
        if (pwr_q == PwrLast) begin
          state_d = StInit;
          step_d  = 4'd0;
        end else begin
          pwr_d = pwr_q + 20'd1;
        end
      end
      StInit: begin
        bus_valid = 1'b1;
        bus_byte  = init_byte(step_q);
        if (bus_ready) begin
          if (step_q == 4'(InitLen - 1)) begin
            state_d = StClear;
            step_d  = 4'd0;
            pix_d   = 20'd0;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
      end
      StClear, StDraw: begin
        bus_valid = 1'b1;
        if (step_q < 4'(WinHdrLen)) begin
          bus_byte = win_byte(step_q, win_x0, win_x1, win_y0, win_y1);
          if (bus_ready) step_d = step_q + 4'd1;
        end else begin
          // High byte on even counts, low byte on odd
          bus_byte = {1'b1, pix_q[0] ? pix_colour[7:0] : pix_colour[15:8]};
          if (bus_ready) begin
            if (pix_q == pix_last) state_d = StIdle;
            else                   pix_d   = pix_q + 20'd1;
          end
        end
      end
      StIdle: begin
        if (pend_valid_q) begin
          pend_valid_d = 1'b0;
          tone_start   = 1'b1;
          case (pend_dir_q)
            DirUp:    if (cy_q == 8'd0) tone_bump = 1'b1; else cy_d = cy_q - 8'd1;
            DirDown:  if (cy_q == YMax) tone_bump = 1'b1; else cy_d = cy_q + 8'd1;
            DirLeft:  if (cx_q == 8'd0) tone_bump = 1'b1; else cx_d = cx_q - 8'd1;
            default:  if (cx_q == XMax) tone_bump = 1'b1; else cx_d = cx_q + 8'd1;
          endcase
          if (!tone_bump && pen_down_q) begin
            state_d    = StDraw;
            step_d     = 4'd0;
            pix_d      = 20'd0;
            draw_col_d = Palette[col_idx_q];
          end
        end
      end
      default: state_d = StPowerup;
    endcase

    // Single-entry request buffer; edges arriving while it is occupied are dropped
    if ((|btn_edge[3:0]) && !pend_valid_q) begin
      pend_valid_d = 1'b1;
      pend_dir_d   = edge_dir;
    end
  end

  // Sequencer and cursor state
  always_ff @(posedge hwclk or negedge reset) begin
    if (!reset) begin
      state_q      <= StPowerup;
      step_q       <= 4'd0;
      pix_q        <= 20'd0;
      pwr_q        <= 20'd0;
      cx_q         <= XRst;
      cy_q         <= YRst;
      draw_col_q   <= 16'h0000;
      pend_valid_q <= 1'b0;
      pend_dir_q   <= DirUp;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      pix_q        <= pix_d;
      pwr_q        <= pwr_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      draw_col_q   <= draw_col_d;
      pend_valid_q <= pend_valid_d;
      pend_dir_q   <= pend_dir_d;
    end
  end

  lcd_bus_writer u_bus (
    .clk_i   (hwclk),
    .rst_ni  (reset),
    .valid_i (bus_valid),
    .data_i  (bus_byte),
    .ready_o (bus_ready),
    .dcx_o   (dcx),
    .wr_o    (wr),
    .d_o     (D)
  );

`ifdef IMGGEN_SOUND_EN
  localparam logic [19:0] ToneLen  = 20'(TONE_CYCLES);
  localparam logic [15:0] HalfMove = 16'(TONE_HALF);
  localparam logic [15:0] HalfBump = 16'(2 * TONE_HALF);

  logic [19:0] tone_rem_q;
  logic [15:0] half_cnt_q, half_len_q;
  logic        level_q;

  // Square wave starting high; a new request restarts it from the beginning
  always_ff @(posedge hwclk or negedge reset) begin
    if (!reset) begin
      tone_rem_q <= 20'd0;
      half_cnt_q <= 16'd0;
      half_len_q <= HalfMove;
      level_q    <= 1'b0;
    end else if (tone_start) begin
      tone_rem_q <= ToneLen;
      half_cnt_q <= 16'd0;
      half_len_q <= tone_bump ? HalfBump : HalfMove;
      level_q    <= 1'b1;
    end else if (tone_rem_q != 20'd0) begin
      tone_rem_q <= tone_rem_q - 20'd1;
      if (half_cnt_q == half_len_q - 16'd1) begin
        half_cnt_q <= 16'd0;
        level_q    <= ~level_q;
      end else begin
        half_cnt_q <= half_cnt_q + 16'd1;
      end
    end
  end

  assign sound_out = (tone_rem_q != 20'd0 && level_q) ? 6'h3F : 6'h00;
`else
  logic unused_tone;
  assign unused_tone = tone_start ^ tone_bump ^ (^32'(TONE_CYCLES + TONE_HALF));
  assign sound_out   = 6'h00;
`endif

endmodule

// File: tb/tb_complete_top.sv
// Scoreboard bench for complete_top with shrunk geometry and timings.
module tb_complete_top;

  localparam int PC = 40;
  localparam int GW = 16;
  localparam int GH = 12;
  localparam int CP = 2;
  localparam int TC = 60;
  localparam int TH = 5;

  localparam logic [15:0] PAL [8] = '{
    16'hFFFF, 16'hF800, 16'h07E0, 16'h001F, 16'hFFE0, 16'hF81F, 16'h07FF, 16'h8410
  };

  logic       tb_clk = 1'b0;
  logic       reset, left, right, up, down, mode_pb, KeyEnc;
  logic       dcx, wr;
  logic [7:0] D;
  logic [5:0] sound_out;

  always #5 tb_clk = ~tb_clk;

  complete_top #(
    .POWERUP_CYCLES (PC),
    .GRID_W         (GW),
    .GRID_H         (GH),
    .CELL_PX        (CP),
    .TONE_CYCLES    (TC),
    .TONE_HALF      (TH)
  ) dut (
    .hwclk     (tb_clk),
    .reset     (reset),
    .left      (left),
    .right     (right),
    .up        (up),
    .down      (down),
    .mode_pb   (mode_pb),
    .KeyEnc    (KeyEnc),
    .dcx       (dcx),
    .wr        (wr),
    .D         (D),
    .sound_out (sound_out)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [8:0]  exp_q [$];

  // Model state
  int   mx, my;
  logic pen;
  int   col;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Every wr-low clock is one byte; compare it against the scoreboard head
  always @(negedge tb_clk) begin
    logic [8:0] e;
    if (reset === 1'b1 && wr === 1'b0) begin
      if (exp_q.size() == 0) begin
        check_eq("bus_extra", {23'b0, dcx, D}, 32'h3FF);
      end else begin
        e = exp_q.pop_front();
        check_eq("bus_byte", {23'b0, dcx, D}, {23'b0, e});
      end
    end
  end

  task automatic push_cmd(input logic [7:0] b);
    exp_q.push_back({1'b0, b});
  endtask

  task automatic push_data(input logic [7:0] b);
    exp_q.push_back({1'b1, b});
  endtask

  task automatic push_word(input int v);
    logic [15:0] w;
    w = 16'(v);
    push_data(w[15:8]);
    push_data(w[7:0]);
  endtask

  task automatic push_window(input int x0, input int x1, input int y0, input int y1,
                             input logic [15:0] c, input int n);
    push_cmd(8'h2A); push_word(x0); push_word(x1);
    push_cmd(8'h2B); push_word(y0); push_word(y1);
    push_cmd(8'h2C);
    for (int i = 0; i < n; i++) begin
      push_data(c[15:8]);
      push_data(c[7:0]);
    end
  endtask

  task automatic push_startup();
    push_cmd(8'h01); push_cmd(8'h11); push_cmd(8'h3A); push_data(8'h55); push_cmd(8'h29);
    push_window(0, GW * CP - 1, 0, GH * CP - 1, 16'h0000, GW * CP * GH * CP);
  endtask

  task automatic model_reset();
    mx = 8; my = 6; pen = 1'b1; col = 0;
  endtask

  // mask = {KeyEnc, mode_pb, right, left, down, up}
  task automatic press(input logic [5:0] mask, input int hold);
    @(negedge tb_clk);
    {KeyEnc, mode_pb, right, left, down, up} = mask;
    repeat (hold) @(negedge tb_clk);
    {KeyEnc, mode_pb, right, left, down, up} = 6'b0;
  endtask

  task automatic do_move(input logic [3:0] dirs, input int hold);
    int nx, ny;
    nx = mx; ny = my;
    if (dirs[0])      ny = my - 1;
    else if (dirs[1]) ny = my + 1;
    else if (dirs[2]) nx = mx - 1;
    else if (dirs[3]) nx = mx + 1;
    if (nx >= 0 && nx < GW && ny >= 0 && ny < GH) begin
      mx = nx; my = ny;
      if (pen) push_window(mx * CP, mx * CP + CP - 1, my * CP, my * CP + CP - 1, PAL[col], CP * CP);
    end
    press({2'b00, dirs}, hold);
  endtask

  task automatic toggle_pen();
    pen = ~pen;
    press(6'b010000, 1);
    repeat (8) @(negedge tb_clk);
  endtask

  task automatic next_colour();
    col = (col + 1) % 8;
    press(6'b100000, 1);
    repeat (8) @(negedge tb_clk);
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 8000) begin
      @(posedge tb_clk);
      t++;
    end
    check_eq(tag, exp_q.size(), 0);
    repeat (30) @(posedge tb_clk);
  endtask

  // Edges after reset release until the first wr low: powerup count plus the registered bus
  task automatic check_first_wr(input string tag);
    int n;
    n = 0;
    while (n < PC + 100) begin
      @(posedge tb_clk);
      #1;
      n++;
      if (wr === 1'b0) break;
    end
    check_eq(tag, n, PC + 1);
    check_eq({tag, "_byte"}, {23'b0, dcx, D}, 32'h001);
  endtask

  task automatic check_tone(input string tag, input int half);
    int waited, bad;
    logic [5:0] tone_exp;
    waited = 0;
    bad    = 0;
`ifdef IMGGEN_SOUND_EN
    while (sound_out !== 6'h3F && waited < 40) begin
      @(posedge tb_clk);
      #1;
      waited++;
    end
    check_eq({tag, "_start"}, {31'b0, waited < 40}, 32'd1);
    for (int i = 0; i < TC + 2 * half; i++) begin
      tone_exp = (i < TC && ((i / half) % 2 == 0)) ? 6'h3F : 6'h00;
      if (sound_out !== tone_exp) bad++;
      @(posedge tb_clk);
      #1;
    end
`else
    for (int i = 0; i < TC + 40; i++) begin
      if (sound_out !== 6'h00) bad++;
      @(posedge tb_clk);
      #1;
      waited++;
    end
`endif
    check_eq(tag, bad, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_dcx"}, {31'b0, dcx}, 32'd1);
    check_eq({tag, "_wr"}, {31'b0, wr}, 32'd1);
    check_eq({tag, "_d"}, {24'b0, D}, 32'h00);
    check_eq({tag, "_sound"}, {26'b0, sound_out}, 32'h00);
  endtask

  initial begin
    int t;
    reset = 1'b1;
    {KeyEnc, mode_pb, right, left, down, up} = 6'b0;
    model_reset();
    #2 reset = 1'b0;
    repeat (2) @(posedge tb_clk);
    #1 check_reset_outputs("rst_hold");
    push_startup();
    @(negedge tb_clk);
    reset = 1'b1;
    #1 check_reset_outputs("rst_release");
    check_first_wr("first_wr");
    wait_drain("startup_drain");

    // Right with pen down paints (9,6) white and sounds the move tone
    do_move(4'b1000, 1);
    check_tone("tone_right", TH);
    wait_drain("draw_right");

    // Two colour steps, pen up, then up: cursor moves with no painting
    next_colour();
    next_colour();
    toggle_pen();
    do_move(4'b0001, 1);
    check_tone("tone_up", TH);
    wait_drain("pen_up_move");

    // Pen down, then down: paints (9,6) in palette entry 2
    toggle_pen();
    do_move(4'b0010, 1);
    wait_drain("draw_down");

    // Walk to the right edge with the pen up
    toggle_pen();
    for (int i = 0; i < 6; i++) begin
      do_move(4'b1000, 1);
      repeat (8) @(negedge tb_clk);
    end
    toggle_pen();
    repeat (TC + 20) @(negedge tb_clk);
    do_move(4'b1000, 1);
    check_tone("tone_bump", 2 * TH);
    wait_drain("bump_quiet");

    // Left from the edge reveals the saturated column
    do_move(4'b0100, 1);
    wait_drain("draw_left");

    // Simultaneous up and left: only up applies
    do_move(4'b0101, 1);
    wait_drain("draw_priority");

    // Held button moves once
    do_move(4'b0010, 30);
    wait_drain("draw_held");

    // Reset in the middle of a draw
    do_move(4'b1000, 1);
    t = 0;
    while (exp_q.size() > 15 && t < 200) begin
      @(posedge tb_clk);
      t++;
    end
    check_eq("draw_started", {31'b0, t < 200}, 32'd1);
    @(posedge tb_clk);
    #2 reset = 1'b0;
    #1 check_reset_outputs("rst_mid_draw");
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge tb_clk);
    push_startup();
    @(negedge tb_clk);
    reset = 1'b1;
    check_first_wr("rerun_first_wr");
    wait_drain("rerun_drain");

    // Cursor and colour are back at their reset values
    do_move(4'b1000, 1);
    wait_drain("draw_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
